fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC, issues pipelined requests to instruction memory, and buffers returned 32-bit VLIW bundles in a small in-order queue. It presents one bundle per cycle to decode under a valid/ready handshake. Branch, jump and exception redirects flush the queue and silently discard responses still in flight from the old stream.

## Interface
- DEPTH, 4: queue entries and maximum outstanding requests combined; power of two, 2..16
- RESET_PC, 32'd0: fetch address after reset
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low; state is cleared on the rising edge where reset==0
- redirect  in  1  flush and restart fetch at redirect_pc (branch, jump, or exception vector 60)
- redirect_pc  in  32  new fetch address; bits [1:0] ignored and treated as 0
- imem_req  out  1  request valid
- imem_addr  out  32  request address, word aligned
- imem_ready  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after acceptance
- imem_rdata  in  32  instruction bundle
- dec_valid  out  1  bundle available to decode
- dec_instr  out  32  bundle
- dec_pc  out  32  bundle address + 4, matching what IF/ID latches as the PC
- dec_ready  in  1  decode accepts the bundle; driven by the hazard unit's IF/ID write enable

## Operation
- State:
  - fetch_pc (32)
  - inflight counter, 0..DEPTH
  - drop counter, 0..DEPTH
  - queue of DEPTH entries, each {addr+4, instr}
- Request issue:
  - imem_req = (entries + inflight < DEPTH) && !redirect
  - imem_addr = fetch_pc
- Handshakes:
  - A request is accepted when imem_req && imem_ready. On acceptance, inflight increments and fetch_pc += 4 (wraps modulo 2^32).
  - Each request records its address so the response can be tagged. Implementation: a DEPTH-entry address FIFO, or pc reconstruction from the queue tail.
  - On response (imem_rvalid): inflight decrements. If drop > 0, drop decrements and the data is discarded. Otherwise the data is pushed into the queue.
  - Dequeue occurs when dec_valid && dec_ready.
- Credit rule: entries + inflight never exceeds DEPTH, so the queue cannot overflow. An imem_rvalid that arrives with no request outstanding is a protocol error; ignore it and do not push.
- Redirect, in a single cycle:
  - The queue empties.
  - drop := inflight − (imem_rvalid ? 1 : 0).
  - fetch_pc := {redirect_pc[31:2], 2'b00}.
  - Any response arriving in the redirect cycle is discarded.
  - dec_valid goes low on the next cycle.
  - A dequeue in the redirect cycle still counts.
- Redirect while drop > 0: drop accumulates across redirects, so every old-stream response is dropped.
- Simultaneous push and pop on a full queue: legal, and the occupancy is unchanged.
- Simultaneous acceptance and response: inflight is unchanged.

## Timing
- Reset values:
  - imem_req = 0, imem_addr = RESET_PC
  - dec_valid = 0, dec_instr = 0, dec_pc = 0
  - all counters and pointers = 0
- imem_req may rise on the first cycle after reset deasserts.
- Latency without bypass: a response in cycle N gives dec_valid in cycle N+1 at the earliest.
- Redirect in cycle N:
  - first new-stream request in cycle N+1
  - new bundle at decode no earlier than N+3, with 1-cycle memory
- dec_valid, dec_instr and dec_pc are stable while dec_valid && !dec_ready.
- Reset asserted mid-operation clears everything on that edge. Instruction memory shares the same reset and returns no responses for pre-reset requests.

## Configuration
- FETCHQ_BYPASS_EN defined:
  - When the queue is empty, drop == 0 and imem_rvalid is high, the response drives dec_instr/dec_pc combinationally in the same cycle with dec_valid = 1.
  - If dec_ready is high, the bundle is consumed without being pushed; otherwise it is pushed.
  - Response-to-decode latency is 0 cycles.
- Undefined: all outputs come from queue registers; latency is 1 cycle as above.
- Counter and credit behaviour is identical in both builds.

## Structure
- The shared package fetch_pkg holds:
  - INSTR_W = 32 and PC_STEP = 4
  - the default RESET_PC
  - the exception vector constant 32'd60, shared with the top-level PC select
  - the queue entry struct {pc_next, instr}
- Sub-module fetch_fifo: a synchronous DEPTH-entry FIFO with push, pop, flush, count, full and empty. It is instantiated once for the bundle queue and optionally once for in-flight addresses.

## Test plan
- Reset, then 1-cycle memory, imem_ready = 1 and dec_ready = 1:
  - addresses 0, 4, 8… issue back-to-back
  - dec_pc sequence is 4, 8, 12…, with one bundle per cycle in steady state
- Hold dec_ready = 0 for 10 cycles with DEPTH = 4:
  - at most 4 requests are accepted, then imem_req stays 0
  - the queue holds bundles 0..12 unchanged
  - on release, they drain in order
- 3-cycle memory with 3 requests outstanding, then redirect to 0x3C:
  - the 3 late responses are dropped
  - the first bundle at decode has dec_pc = 0x40
- Redirect in the same cycle as imem_rvalid, then a second redirect 1 cycle later: drop accounting discards every old response, and only the second target's bundles appear.
- redirect_pc = 0xFFFFFFFC: fetch wraps to 0x00000000 and dec_pc = 0x00000000.
- Assert reset mid-stream with a full queue: the next cycle shows dec_valid = 0, imem_addr = RESET_PC, and fetching resumes from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared constants and types for the instruction-fetch front end.
//   INSTR_W          : width of one VLIW bundle
//   PC_STEP          : fetch address increment per bundle
//   DEFAULT_RESET_PC : fetch address after reset
//   EXC_VECTOR       : exception vector, also used by the top-level PC select
//   fq_entry_t       : one bundle-queue entry {pc_next, instr}
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;
  localparam logic [31:0] EXC_VECTOR       = 32'd60;

  // pc_next is the bundle address + 4, which is what IF/ID latches as the PC.
  typedef struct packed {
    logic [31:0]        pc_next;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous DEPTH-entry FIFO (DEPTH a power of two) with flush.
// Ports:
//   clk, reset (sync, active-low)
//   push/din   : write din when not full (or when full and popping)
//   pop/dout   : dout shows the head entry; pop advances when not empty
//   flush      : empties the FIFO, takes priority over push/pop
//   count      : current occupancy 0..DEPTH
//   full/empty : occupancy flags
// ---------------------------------------------------------------------------
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal when the same cycle pops.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // can leave one unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: ;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy is, and consumers
  // qualify dout with !empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Instruction-fetch front end feeding the IF/ID register. Owns the fetch PC,
// issues pipelined imem requests under a credit limit, buffers returned
// bundles in order and presents them to decode with valid/ready. A redirect
// flushes the queue and drops every response still in flight.
// Ports:
//   clk, reset (sync, active-low)
//   redirect, redirect_pc      : restart fetch at {redirect_pc[31:2], 2'b00}
//   imem_req, imem_addr        : request out, accepted when imem_ready
//   imem_rvalid, imem_rdata    : in-order responses
//   dec_valid, dec_instr,
//   dec_pc, dec_ready          : bundle to decode, dec_pc = bundle addr + 4
// Build option:
//   FETCHQ_BYPASS_EN : a response arriving into an empty queue (and not being
//                      dropped) is presented to decode in the same cycle.
// ---------------------------------------------------------------------------
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        dec_ready
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [CNT_W-1:0] q_count, inflight;
  logic             q_empty, a_empty;
  logic             unused_q_full, unused_a_full, unused_pc_lsbs;
  logic [CNT_W:0]   used;
  fq_entry_t        q_din, q_dout, dec_entry;
  logic [31:0]      a_dout;
  logic             accept, rsp_live, rsp_keep, q_push, q_pop;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  // Queue entries plus outstanding requests may never exceed DEPTH, which
  // is what guarantees every response has a free queue slot.
  assign used     = {1'b0, q_count} + {1'b0, inflight};
  assign imem_req = reset && !redirect && (used < (CNT_W+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign accept   = imem_req && imem_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_live = imem_rvalid && !a_empty;
  // Old-stream responses (drop_q > 0) and any response in a redirect cycle
  // are discarded.
  assign rsp_keep = rsp_live && (drop_q == '0) && !redirect;

  assign q_din = '{pc_next: a_dout + PC_STEP, instr: imem_rdata};
  assign q_pop = dec_ready && !q_empty;

`ifdef FETCHQ_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = q_empty && rsp_keep;
  // A bypassed bundle that decode takes this cycle never enters the queue.
  assign q_push     = rsp_keep && !(bypass_hit && dec_ready);
  assign dec_valid  = !q_empty || bypass_hit;
`else
  assign q_push     = rsp_keep;
  assign dec_valid  = !q_empty;
`endif

  always_comb begin
    dec_entry = '0;
    if (!q_empty) dec_entry = q_dout;
`ifdef FETCHQ_BYPASS_EN
    else if (bypass_hit) dec_entry = q_din;
`endif
  end

  assign dec_instr = dec_entry.instr;
  assign dec_pc    = dec_entry.pc_next;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      // Everything still outstanding after this cycle belongs to the old
      // stream; drop_q <= inflight always, so this also covers redirects
      // that land while earlier drops are still pending.
      drop_d = inflight - (rsp_live ? CNT_ONE : '0);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (rsp_live && (drop_q != '0)) drop_d = drop_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

  // Bundle queue.
  fetch_fifo #(.WIDTH($bits(fq_entry_t)), .DEPTH(DEPTH)) u_bundle_q (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect),
    .din   (q_din),
    .dout  (q_dout),
    .count (q_count),
    .full  (unused_q_full),
    .empty (q_empty)
  );

  // Request addresses in flight; its occupancy is the inflight counter.
  // Never flushed: dropped responses still retire their own entry.
  fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_addr_q (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (rsp_live),
    .flush (1'b0),
    .din   (fetch_pc_q),
    .dout  (a_dout),
    .count (inflight),
    .full  (unused_a_full),
    .empty (a_empty)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
// Directed bench for fetch_queue (default build, DEPTH = 4, RESET_PC = 0).
// A small instruction-memory model returns ~addr as the bundle after a
// configurable latency; bundles taken by decode are logged for checking.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset, redirect, imem_ready, imem_rvalid, dec_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, dec_valid;
  logic [31:0] imem_addr, dec_instr, dec_pc;

  fetch_queue dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .dec_valid   (dec_valid),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .dec_ready   (dec_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_instr[$];
  int          cyc = 0;
  int          lat = 1;
  int          acc_count = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] got_pc_at(int i);
    if (i < got_pc.size()) return got_pc[i];
    return 32'hBAD0_BAD0;
  endfunction

  function automatic logic [31:0] got_instr_at(int i);
    if (i < got_instr.size()) return got_instr[i];
    return 32'hBAD0_BAD0;
  endfunction

  // One clock: sample handshakes before the edge, update the memory model
  // after it, drive the next response, then let the design settle.
  task automatic tick();
    logic        acc, rsp, cons;
    logic [31:0] a, cp, ci;
    acc  = imem_req && imem_ready;
    a    = imem_addr;
    rsp  = imem_rvalid && (mq.size() > 0);
    cons = dec_valid && dec_ready;
    cp   = dec_pc;
    ci   = dec_instr;
    @(posedge clk);
    #1;
    cyc++;
    if (!reset) begin
      mq.delete();
    end else begin
      if (rsp) void'(mq.pop_front());
      if (acc) begin
        mq.push_back('{a, cyc - 1 + lat});
        acc_count++;
      end
      if (cons) begin
        got_pc.push_back(cp);
        got_instr.push_back(ci);
      end
    end
    if (reset && (mq.size() > 0) && (mq[0].due <= cyc)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = ~mq[0].addr;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
    end
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    got_pc.delete();
    got_instr.delete();
    acc_count = 0;
  endtask

  initial begin
    reset = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    dec_ready = 1'b0;

    // ---- reset values
    tick();
    check("rst_req",   32'(imem_req),  32'd0);
    check("rst_addr",  imem_addr,      32'd0);
    check("rst_valid", 32'(dec_valid), 32'd0);
    check("rst_instr", dec_instr,      32'd0);
    check("rst_pc",    dec_pc,         32'd0);
    tick();
    reset = 1'b1; dec_ready = 1'b1; #1;

    // ---- 1: streaming with 1-cycle memory
    check("t1_req0",   32'(imem_req),  32'd1);
    check("t1_addr0",  imem_addr,      32'h0);
    tick();
    check("t1_addr1",  imem_addr,      32'h4);
    check("t1_valid1", 32'(dec_valid), 32'd0);
    tick();
    check("t1_addr2",  imem_addr,      32'h8);
    check("t1_valid2", 32'(dec_valid), 32'd1);
    check("t1_pc2",    dec_pc,         32'h4);
    repeat (5) tick();
    check("t1_count",  32'(got_pc.size()), 32'd5);
    check("t1_got0",   got_pc_at(0),   32'h4);
    check("t1_got1",   got_pc_at(1),   32'h8);
    check("t1_got2",   got_pc_at(2),   32'hC);
    check("t1_got3",   got_pc_at(3),   32'h10);
    check("t1_ins1",   got_instr_at(1), 32'hFFFF_FFFB);

    // ---- 2: decode stalled for 10 cycles, then drain
    dec_ready = 1'b0;
    reset_dut();
    repeat (10) tick();
    check("t2_accepts", 32'(acc_count), 32'd4);
    check("t2_req",     32'(imem_req),  32'd0);
    check("t2_valid",   32'(dec_valid), 32'd1);
    check("t2_hold_pc", dec_pc,         32'h4);
    check("t2_hold_in", dec_instr,      32'hFFFF_FFFF);
    dec_ready = 1'b1; #1;
    got_pc.delete(); got_instr.delete();
    repeat (8) tick();
    check("t2_got0", got_pc_at(0), 32'h4);
    check("t2_got1", got_pc_at(1), 32'h8);
    check("t2_got2", got_pc_at(2), 32'hC);
    check("t2_got3", got_pc_at(3), 32'h10);
    check("t2_got4", got_pc_at(4), 32'h14);
    check("t2_ins3", got_instr_at(3), 32'hFFFF_FFF3);

    // ---- 3: 3-cycle memory, 3 outstanding, redirect to 0x3C
    lat = 3;
    reset_dut();
    repeat (3) tick();
    check("t3_accepts", 32'(acc_count), 32'd3);
    redirect = 1'b1; redirect_pc = 32'h3C; #1;
    check("t3_req_blk", 32'(imem_req), 32'd0);
    got_pc.delete(); got_instr.delete();
    tick();
    redirect = 1'b0; #1;
    check("t3_req_new", 32'(imem_req),  32'd1);
    check("t3_addr",    imem_addr,      32'h3C);
    check("t3_valid",   32'(dec_valid), 32'd0);
    repeat (10) tick();
    check("t3_got0", got_pc_at(0),    32'h40);
    check("t3_ins0", got_instr_at(0), 32'hFFFF_FFC3);
    check("t3_got1", got_pc_at(1),    32'h44);

    // ---- 4: redirect with a response, then a second redirect next cycle
    reset_dut();
    repeat (3) tick();
    redirect = 1'b1; redirect_pc = 32'h100; #1;
    got_pc.delete(); got_instr.delete();
    tick();
    redirect_pc = 32'h200; #1;
    check("t4_req_blk", 32'(imem_req), 32'd0);
    tick();
    redirect = 1'b0; #1;
    check("t4_req",  32'(imem_req), 32'd1);
    check("t4_addr", imem_addr,     32'h200);
    repeat (10) tick();
    check("t4_got0", got_pc_at(0),    32'h204);
    check("t4_ins0", got_instr_at(0), 32'hFFFF_FDFF);
    check("t4_got1", got_pc_at(1),    32'h208);

    // ---- 5: redirect from a full queue to 0xFFFFFFFC (lsbs ignored), wrap
    lat = 1; dec_ready = 1'b0;
    reset_dut();
    repeat (6) tick();
    check("t5_full_valid", 32'(dec_valid), 32'd1);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
    tick();
    redirect = 1'b0; #1;
    check("t5_valid", 32'(dec_valid), 32'd0);
    check("t5_addr",  imem_addr,      32'hFFFF_FFFC);
    check("t5_req",   32'(imem_req),  32'd1);
    got_pc.delete(); got_instr.delete();
    dec_ready = 1'b1; #1;
    tick();
    check("t5_wrap",  imem_addr,      32'h0);
    repeat (5) tick();
    check("t5_got0",  got_pc_at(0),    32'h0);
    check("t5_ins0",  got_instr_at(0), 32'h3);
    check("t5_got1",  got_pc_at(1),    32'h4);

    // ---- 6: reset mid-stream with a full queue, stray response afterwards
    dec_ready = 1'b0;
    reset_dut();
    repeat (6) tick();
    check("t6_full_valid", 32'(dec_valid), 32'd1);
    reset = 1'b0; #1;
    tick();
    check("t6_valid", 32'(dec_valid), 32'd0);
    check("t6_addr",  imem_addr,      32'h0);
    check("t6_req",   32'(imem_req),  32'd0);
    reset = 1'b1; dec_ready = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    check("t6_req1",  32'(imem_req),  32'd1);
    check("t6_addr1", imem_addr,      32'h0);
    got_pc.delete(); got_instr.delete();
    tick();
    check("t6_stray", 32'(dec_valid), 32'd0);
    repeat (4) tick();
    check("t6_got0",  got_pc_at(0),    32'h4);
    check("t6_ins0",  got_instr_at(0), 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
